stbus_rx: RTL and testbench

STBUS_RX -- requirements
Module: stbus_rx

---
 rtl/stbus_pkg.sv | 20 ++
 rtl/stbus_sync.sv | 31 +++
 rtl/stbus_rx.sv | 116 +++++++++++
 tb/tb_stbus_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/stbus_pkg.sv
// stbus_pkg: shared frame constants, test-pattern helper and receiver state type.
// Contents:
//   CHANNELS, BITS_PER_CH, FRAME_BITS  frame geometry (32 x 8 = 256 bits)
//   PAT_CH, PAT_NCH                    test pattern: first PAT_NCH channels carry PAT_CH, rest 0
//   state_t                            HUNT / ALIGN / RECEIVE
//   pat_byte()                         expected test-pattern byte for a channel index
`timescale 1ns/1ps
package stbus_pkg;
    localparam int         CHANNELS    = 32;
    localparam int         BITS_PER_CH = 8;
    localparam int         FRAME_BITS  = CHANNELS * BITS_PER_CH;
    localparam logic [7:0] PAT_CH      = 8'hAA;
    localparam int         PAT_NCH     = 4;

    typedef enum logic [1:0] {HUNT, ALIGN, RECEIVE} state_t;

    function automatic logic [7:0] pat_byte(input logic [4:0] ch);
        return (ch < 5'(PAT_NCH)) ? PAT_CH : 8'h00;
    endfunction
endpackage

// File: rtl/stbus_sync.sv
// stbus_sync: two-flop synchronizer with rising-edge detect on the synchronized level.
// Ports:
//   clk   in   destination clock
//   rst   in   synchronous active-high reset, clears all flops
//   d     in   asynchronous input
//   q     out  synchronized level (two flops of delay)
//   rise  out  one-cycle pulse when q goes 0 -> 1
`timescale 1ns/1ps
module stbus_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);
    logic meta, q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
            q_d  <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign rise = q & ~q_d;
endmodule

// File: rtl/stbus_rx.sv
// stbus_rx: serial frame receiver; deserializes MSB-first channels framed by an active-low f0 pulse.
// Ports:
//   clk50         in   system clock, all logic on its rising edge
//   reset_in_rg   in   synchronous active-high reset
//   c4            in   async bit clock, one bit per rising edge
//   f0            in   async frame pulse, active low
//   data_from_dt  in   async serial data
//   ch_valid      out  pulse: ch_num/ch_data hold a completed channel
//   ch_num        out  index of completed channel
//   ch_data       out  completed channel byte, first bit received in bit 7
//   frame_done    out  pulse with the last channel of a full frame
//   pattern_ok    out  frame matched the test pattern, updated with frame_done
//   frame_err     out  pulse on a framing violation
//   in_sync       out  high while receiving
`timescale 1ns/1ps
module stbus_rx import stbus_pkg::*; #(
    parameter int CHANNELS    = stbus_pkg::CHANNELS,
    parameter int BITS_PER_CH = stbus_pkg::BITS_PER_CH
) (
    input  logic       clk50,
    input  logic       reset_in_rg,
    input  logic       c4,
    input  logic       f0,
    input  logic       data_from_dt,
    output logic       ch_valid,
    output logic [4:0] ch_num,
    output logic [7:0] ch_data,
    output logic       frame_done,
    output logic       pattern_ok,
    output logic       frame_err,
    output logic       in_sync
);
    localparam int FBITS = CHANNELS * BITS_PER_CH;

    state_t     state, nxt;
    logic       c4_ev, f0_s, d_s, f0_prev;
    logic       c4_unused, f0_rise_unused, d_rise_unused;
    logic [8:0] bit_cnt, cnt_inc;
    logic [7:0] shreg, byte_nxt;
    logic [4:0] idx;
    logic       f0_start, at_end, cap, err, byte_done, last_byte, run_ok, run_nxt;

    // Identical synchronizers keep c4, f0 and data aligned to the same clk50 cycle.
    stbus_sync u_c4 (.clk(clk50), .rst(reset_in_rg), .d(c4),           .q(c4_unused), .rise(c4_ev));
    stbus_sync u_f0 (.clk(clk50), .rst(reset_in_rg), .d(f0),           .q(f0_s),      .rise(f0_rise_unused));
    stbus_sync u_d  (.clk(clk50), .rst(reset_in_rg), .d(data_from_dt), .q(d_s),       .rise(d_rise_unused));

    // f0 is only meaningful at c4 events; a start is its high-to-low transition between events.
    assign f0_start  = c4_ev & ~f0_s & f0_prev;
    assign at_end    = bit_cnt == 9'(FBITS);
    assign cnt_inc   = bit_cnt + 9'd1;
    assign byte_nxt  = {shreg[6:0], d_s};
    assign byte_done = cap && (cnt_inc % 9'(BITS_PER_CH)) == 9'd0;
    assign last_byte = cnt_inc == 9'(FBITS);
    assign idx       = 5'(cnt_inc / 9'(BITS_PER_CH) - 9'd1);
    // Channel 0 restarts the running match so an aborted frame cannot poison the next one.
    assign run_nxt   = (idx == 5'd0 || run_ok) && byte_nxt == pat_byte(idx);

    // f0 start is tested before overrun so a coincident start resyncs instead of dropping to HUNT.
    always_comb begin
        nxt = state;
        cap = 1'b0;
        err = 1'b0;
        case (state)
            HUNT:    if (f0_start) nxt = ALIGN;
            ALIGN:   if (c4_ev && f0_s) begin
                         nxt = RECEIVE;
                         cap = 1'b1;
                     end
            RECEIVE: if (f0_start) begin
                         nxt = ALIGN;
                         err = !at_end;
                     end else if (c4_ev && f0_s) begin
                         if (at_end) begin
                             nxt = HUNT;
                             err = 1'b1;
                         end else begin
                             cap = 1'b1;
                         end
                     end
            default: nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset_in_rg) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            shreg      <= '0;
            f0_prev    <= 1'b0;
            run_ok     <= 1'b0;
            ch_valid   <= 1'b0;
            ch_num     <= '0;
            ch_data    <= '0;
            frame_done <= 1'b0;
            pattern_ok <= 1'b0;
            frame_err  <= 1'b0;
            in_sync    <= 1'b0;
        end else begin
            state      <= nxt;
            bit_cnt    <= (nxt != RECEIVE) ? 9'd0 : cap ? cnt_inc : bit_cnt;
            f0_prev    <= c4_ev ? f0_s : f0_prev;
            shreg      <= cap ? byte_nxt : shreg;
            ch_valid   <= byte_done;
            frame_done <= byte_done && last_byte;
            frame_err  <= err;
            in_sync    <= nxt == RECEIVE;
            if (byte_done) begin
                ch_num  <= idx;
                ch_data <= byte_nxt;
                run_ok  <= run_nxt;
            end
            if (byte_done && last_byte) pattern_ok <= run_nxt;
        end
    end
endmodule

// File: tb/tb_stbus_rx.sv
// tb_stbus_rx: directed frames for stbus_rx with a queued scoreboard and an independent output monitor.
`timescale 1ns/1ps
module tb_stbus_rx;
    logic       clk50 = 1'b0, reset_in_rg = 1'b1, c4 = 1'b0, f0 = 1'b1, data_from_dt = 1'b0;
    logic       ch_valid, frame_done, pattern_ok, frame_err, in_sync;
    logic [4:0] ch_num;
    logic [7:0] ch_data;

    typedef struct packed {
        logic       v;
        logic [4:0] num;
        logic [7:0] data;
        logic       fd;
        logic       pat;
        logic       fe;
    } ev_t;

    ev_t        exp_q[$];
    int         n_chk = 0, n_pass = 0;
    logic [7:0] frm [32];
    logic       pat_exp;

    stbus_rx dut (
        .clk50(clk50), .reset_in_rg(reset_in_rg), .c4(c4), .f0(f0), .data_from_dt(data_from_dt),
        .ch_valid(ch_valid), .ch_num(ch_num), .ch_data(ch_data), .frame_done(frame_done),
        .pattern_ok(pattern_ok), .frame_err(frame_err), .in_sync(in_sync)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b, input logic fd, input logic pat);
        ev_t e;
        e = '0;
        e.v = 1'b1;
        e.num = 5'(ch);
        e.data = b;
        e.fd = fd;
        e.pat = fd ? pat : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e = '0;
        e.fe = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk50) begin
        ev_t a, e;
        if (ch_valid || frame_done || frame_err) begin
            a = '0;
            a.v = ch_valid;
            a.num = ch_valid ? ch_num : 5'd0;
            a.data = ch_valid ? ch_data : 8'd0;
            a.fd = frame_done;
            a.pat = frame_done ? pattern_ok : 1'b0;
            a.fe = frame_err;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("event", 32'(a), 32'(e));
        end
    end

    // One c4 period of 244 ns (~4.096 MHz); inputs change while c4 is low.
    task automatic edge_c4(input logic fv, input logic dv, input bit lat);
        time t;
        f0 = fv;
        data_from_dt = dv;
        #122 c4 = 1'b1;
        if (lat) begin
            t = $time;
            repeat (2) @(posedge clk50);
            #1 chk("latency_pre", 32'(ch_valid), 32'd0);
            @(posedge clk50);
            #1 chk("latency_hit", 32'(ch_valid), 32'd1);
            #(122 - ($time - t));
        end else begin
            #122;
        end
        c4 = 1'b0;
    endtask

    task automatic lead(input int nlow, input bit err);
        for (int i = 0; i < nlow; i++) begin
            if (err && i == 0) push_err();
            edge_c4(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_bits(input int n, input bit lat);
        for (int k = 0; k < n; k++) begin
            logic b;
            b = frm[k / 8][7 - (k % 8)];
            if (k % 8 == 7) push_byte(k / 8, frm[k / 8], k == 255, pat_exp);
            edge_c4(1'b1, b, lat && k == 7);
        end
    endtask

    task automatic set_pattern();
        for (int i = 0; i < 32; i++) frm[i] = (i < 4) ? 8'hAA : 8'h00;
        pat_exp = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_pattern();
        repeat (3) @(negedge clk50);
        chk("reset_outputs", 32'({ch_valid, ch_num, ch_data, frame_done, pattern_ok, frame_err, in_sync}), 32'd0);
        reset_in_rg = 1'b0;
        #1;
        repeat (4) edge_c4(1'b1, 1'b0, 1'b0);
        chk("hunt_in_sync", 32'(in_sync), 32'd0);

        for (int f = 0; f < 3; f++) begin
            lead(1, 1'b0);
            send_bits(256, f == 0);
            chk("frame_in_sync", 32'(in_sync), 32'd1);
        end

        frm[7] = 8'h5A;
        pat_exp = 1'b0;
        lead(1, 1'b0);
        send_bits(256, 1'b0);
        set_pattern();

        lead(3, 1'b0);
        send_bits(256, 1'b0);

        lead(1, 1'b0);
        send_bits(200, 1'b0);
        lead(1, 1'b1);
        send_bits(256, 1'b0);

        lead(1, 1'b0);
        send_bits(256, 1'b0);
        push_err();
        edge_c4(1'b1, 1'b0, 1'b0);
        chk("overrun_in_sync", 32'(in_sync), 32'd0);
        repeat (43) edge_c4(1'b1, 1'b0, 1'b0);
        chk("overrun_hunt", 32'(in_sync), 32'd0);
        lead(1, 1'b0);
        send_bits(256, 1'b0);

        lead(1, 1'b0);
        send_bits(100, 1'b0);
        @(negedge clk50);
        reset_in_rg = 1'b1;
        repeat (2) @(negedge clk50);
        chk("midframe_reset", 32'({ch_valid, ch_num, ch_data, frame_done, pattern_ok, frame_err, in_sync}), 32'd0);
        reset_in_rg = 1'b0;
        #1;
        repeat (20) edge_c4(1'b1, 1'b1, 1'b0);
        chk("post_reset_idle", 32'(in_sync), 32'd0);
        lead(1, 1'b0);
        send_bits(256, 1'b0);

        repeat (50) @(negedge clk50);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
